instruction_fetch: RTL

Pipeline stage 1: fetches 32-bit instruction words from the instruction cache and predicts branch direction with a 2-bit saturating-counter FSM. Produces the compressed 30-bit instruction word, PC and prediction bit registered into the IF/ID boundary, which the decode stage consumes. Also handles load-use hazard holds, data-memory stalls and branch-mispredict flushes.

---
 rtl/instruction_fetch_pkg.sv | 40 ++++
 rtl/instruction_fetch_branch_predictor_2bit.sv | 30 +++
 rtl/instruction_fetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared IF-stage constants: opcode classes, bubble word and 2-bit predictor encodings.
// The predictor helpers are only called when IF_BRANCH_PREDICT_EN is defined.
package instruction_fetch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [29:0] IF_NOP_WORD = 30'h0000_0004;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  typedef enum logic [1:0] {
    K_OTHER  = 2'd0,
    K_BRANCH = 2'd1,
    K_JAL    = 2'd2,
    K_JALR   = 2'd3
  } op_kind_e;

  function automatic op_kind_e opcode_kind(input logic [6:0] op);
    if (op == OP_BRANCH) return K_BRANCH;
    if (op == OP_JAL)    return K_JAL;
    if (op == OP_JALR)   return K_JALR;
    return K_OTHER;
  endfunction

  // Saturating counter step: taken counts up toward STRONG_T, not-taken down toward STRONG_NT.
  function automatic logic [1:0] bp_next(input logic [1:0] s, input logic taken);
    if (taken) return (s == STRONG_T) ? STRONG_T : s + 2'd1;
    return (s == STRONG_NT) ? STRONG_NT : s - 2'd1;
  endfunction

  function automatic logic bp_predict(input logic [1:0] s);
    return (s == WEAK_T) || (s == STRONG_T);
  endfunction

endpackage

// File: rtl/instruction_fetch_branch_predictor_2bit.sv
// 2-bit saturating-counter branch direction predictor.
// Present only when IF_BRANCH_PREDICT_EN is defined.
`ifdef IF_BRANCH_PREDICT_EN
module branch_predictor_2bit
  import instruction_fetch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic update_i,
  input  logic taken_i,
  output logic pred_taken_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (update_i) state_d = bp_next(state_q, taken_i);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WEAK_NT;
    else     state_q <= state_d;
  end

  assign pred_taken_o = bp_predict(state_q);

endmodule
`endif

// File: rtl/instruction_fetch.sv
// IF stage: PC register, static pre-decode of B-type/JAL targets and the IF/ID register.
// IF_BRANCH_PREDICT_EN adds a 2-bit dynamic predictor for B-type; otherwise only JAL is taken.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [29:0] NOP_WORD = IF_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic        ICACHE_stall,
  input  logic [31:0] ICACHE_rdata,
  input  logic        memory_stall,
  input  logic        PC_write,
  input  logic [29:0] IF_DWrite,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic        flush,
  input  logic [31:0] resolve_target,
  output logic [29:0] instruction_1,
  output logic [31:0] PC_1,
  output logic        prev_taken_1
);

  logic        stall;
  logic [31:0] pc_q, pc_d;
  logic [29:0] instr_q, instr_d;
  logic [31:0] pc1_q, pc1_d;
  logic        prev_q, prev_d;

  op_kind_e    kind;
  logic [31:0] imm_b, imm_j, next_pc;
  logic        bp_taken, pred;

  assign stall = ICACHE_stall | memory_stall;

`ifdef IF_BRANCH_PREDICT_EN
  branch_predictor_2bit u_bp (
    .clk          (clk),
    .rst          (rst),
    .update_i     (resolve_valid & ~stall),
    .taken_i      (resolve_taken),
    .pred_taken_o (bp_taken)
  );
`else
  logic unused_resolve;
  assign unused_resolve = resolve_valid ^ resolve_taken;
  assign bp_taken = 1'b0;
`endif

  always_comb begin
    kind    = opcode_kind(ICACHE_rdata[6:0]);
    imm_b   = {{20{ICACHE_rdata[31]}}, ICACHE_rdata[7], ICACHE_rdata[30:25],
               ICACHE_rdata[11:8], 1'b0};
    imm_j   = {{12{ICACHE_rdata[31]}}, ICACHE_rdata[19:12], ICACHE_rdata[20],
               ICACHE_rdata[30:21], 1'b0};
    pred    = (kind == K_JAL) | ((kind == K_BRANCH) & bp_taken);
    next_pc = pc_q + (pred ? ((kind == K_JAL) ? imm_j : imm_b) : 32'd4);
  end

  // Stall freezes everything; flush squashes even a concurrent load-use hold.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    prev_d  = prev_q;
    if (!stall) begin
      if (flush) begin
        pc_d    = resolve_target;
        instr_d = NOP_WORD;
        pc1_d   = pc_q;
        prev_d  = 1'b0;
      end else if (PC_write) begin
        instr_d = IF_DWrite;
      end else begin
        pc_d    = next_pc;
        instr_d = ICACHE_rdata[31:2];
        pc1_d   = pc_q;
        prev_d  = pred;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc1_q   <= 32'h0;
      prev_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      prev_q  <= prev_d;
    end
  end

  assign ICACHE_ren    = ~rst;
  assign ICACHE_addr   = pc_q[31:2];
  assign instruction_1 = instr_q;
  assign PC_1          = pc1_q;
  assign prev_taken_1  = prev_q;

endmodule
